contador_param: RTL and testbench

//  Parametrised up/down modulo-N counter: next generation of the ALU 4-bit counter.

---
 rtl/contador_param.sv | 102 ++++++++++
 tb/tb_contador_param.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/contador_param.sv
// contador_param: parametrised up/down modulo-N counter with parallel load, wrap/saturate
// mode and boundary flags. Optional prescaler when CONTADOR_PRESCALER_EN is defined.
module contador_param #(
  parameter int WIDTH    = 4,
  parameter int MODULO   = 2**WIDTH,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             ovf,
  output logic             unf,
  output logic             zero
);

  localparam logic [WIDTH:0]   LP_MOD    = (WIDTH+1)'(MODULO);
  localparam logic [WIDTH:0]   LP_LAST   = LP_MOD - (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] LP_LAST_Q = LP_LAST[WIDTH-1:0];
  localparam logic [WIDTH-1:0] LP_ONE_Q  = WIDTH'(1);

  generate
    if (WIDTH < 1 || MODULO < 2 || MODULO > 2**WIDTH || PRESCALE < 1) begin : g_badParams
      $error("contador_param: illegal WIDTH/MODULO/PRESCALE combination");
    end
  endgenerate

  logic [WIDTH-1:0] r_q;
  logic             r_ovf;
  logic             r_unf;
  logic             w_tick;
  logic             w_step;
  logic             w_atLast;
  logic             w_atZero;
  logic [WIDTH:0]   w_qExt;
  logic [WIDTH:0]   w_loadExt;
  logic [WIDTH-1:0] w_next;

  // Comparisons are done one bit wider so MODULO == 2**WIDTH is representable.
  assign w_qExt    = {1'b0, r_q};
  assign w_loadExt = {1'b0, load_val};
  assign w_atLast  = (w_qExt == LP_LAST);
  assign w_atZero  = (w_qExt == '0);
  assign w_step    = en & w_tick;

`ifdef CONTADOR_PRESCALER_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LP_PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] r_pre;

  assign w_tick = (r_pre == LP_PRE_LAST);

  always_ff @(posedge clk) begin
    if (rst || load) begin
      r_pre <= '0;
    end else if (en) begin
      r_pre <= w_tick ? '0 : r_pre + PW'(1);
    end
  end
`else
  assign w_tick = 1'b1;
`endif

  always_comb begin
    w_next = r_q;
    if (load) begin
      w_next = (w_loadExt >= LP_MOD) ? LP_LAST_Q : load_val;
    end else if (w_step) begin
      if (up) begin
        w_next = w_atLast ? (sat ? r_q : '0) : r_q + LP_ONE_Q;
      end else begin
        w_next = w_atZero ? (sat ? '0 : LP_LAST_Q) : r_q - LP_ONE_Q;
      end
    end
  end

  // Boundary flags are single-cycle pulses recomputed every edge, so they never stick.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q   <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_q   <= w_next;
      r_ovf <= ~load & w_step & up & w_atLast;
      r_unf <= ~load & w_step & ~up & w_atZero;
    end
  end

  assign Q    = r_q;
  assign ovf  = r_ovf;
  assign unf  = r_unf;
  assign zero = w_atZero;
  assign tc   = w_step & (up ? w_atLast : w_atZero);

endmodule

// File: tb/tb_contador_param.sv
// tb_contador_param: drives a MODULO=10 and a MODULO=16 counter with directed and random
// stimulus, comparing both against an arithmetic reference model.
module tb_contador_param;

  localparam int W = 4;
`ifdef CONTADOR_PRESCALER_EN
  localparam int TB_PRESCALE = 3;
`else
  localparam int TB_PRESCALE = 1;
`endif

  logic         clk;
  logic         rst;
  logic         en;
  logic         up;
  logic         sat;
  logic         load;
  logic [W-1:0] loadVal;

  logic [W-1:0] q0, q1;
  logic         tc0, tc1, ovf0, ovf1, unf0, unf1, zero0, zero1;

  int errors = 0;
  int checks = 0;

  int mq   [2];
  int mpre [2];
  int movf [2];
  int munf [2];

  contador_param #(.WIDTH(W), .MODULO(10), .PRESCALE(TB_PRESCALE)) dut10 (
    .clk(clk), .rst(rst), .en(en), .up(up), .sat(sat), .load(load), .load_val(loadVal),
    .Q(q0), .tc(tc0), .ovf(ovf0), .unf(unf0), .zero(zero0)
  );

  contador_param #(.WIDTH(W), .MODULO(16), .PRESCALE(TB_PRESCALE)) dut16 (
    .clk(clk), .rst(rst), .en(en), .up(up), .sat(sat), .load(load), .load_val(loadVal),
    .Q(q1), .tc(tc1), .ovf(ovf1), .unf(unf1), .zero(zero1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int modOf(input int k);
    return (k == 0) ? 10 : 16;
  endfunction

  function automatic bit stepOf(input int k);
    return en && (mpre[k] == TB_PRESCALE - 1);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drives one cycle of inputs, checks combinational outputs before the edge and
  // registered outputs after it.
  task automatic applyStimulus(input bit r, input bit e, input bit u, input bit s,
                               input bit l, input int lv, input string tag);
    int m;
    int expTc;
    rst = r; en = e; up = u; sat = s; load = l; loadVal = W'(lv);
    #1;
    for (int k = 0; k < 2; k++) begin
      m = modOf(k);
      expTc = (stepOf(k) && (u ? (mq[k] == m - 1) : (mq[k] == 0))) ? 1 : 0;
      if (k == 0) begin
        checkOutput($sformatf("%s m10 tc", tag), 32'(tc0), 32'(expTc));
        checkOutput($sformatf("%s m10 zero", tag), 32'(zero0), 32'(mq[k] == 0));
      end else begin
        checkOutput($sformatf("%s m16 tc", tag), 32'(tc1), 32'(expTc));
        checkOutput($sformatf("%s m16 zero", tag), 32'(zero1), 32'(mq[k] == 0));
      end
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      bit st;
      m = modOf(k);
      st = stepOf(k);
      if (r) begin
        mq[k] = 0; movf[k] = 0; munf[k] = 0; mpre[k] = 0;
      end else if (l) begin
        mq[k] = (lv >= m) ? m - 1 : lv;
        movf[k] = 0; munf[k] = 0; mpre[k] = 0;
      end else begin
        movf[k] = (st && u && mq[k] == m - 1) ? 1 : 0;
        munf[k] = (st && !u && mq[k] == 0) ? 1 : 0;
        if (st) begin
          if (u) mq[k] = (s && mq[k] == m - 1) ? mq[k] : (mq[k] + 1) % m;
          else   mq[k] = (s && mq[k] == 0) ? 0 : (mq[k] + m - 1) % m;
        end
        if (e) mpre[k] = (mpre[k] + 1) % TB_PRESCALE;
      end
    end
    #1;
    checkOutput($sformatf("%s m10 Q", tag), 32'(q0), 32'(mq[0]));
    checkOutput($sformatf("%s m10 ovf", tag), 32'(ovf0), 32'(movf[0]));
    checkOutput($sformatf("%s m10 unf", tag), 32'(unf0), 32'(munf[0]));
    checkOutput($sformatf("%s m16 Q", tag), 32'(q1), 32'(mq[1]));
    checkOutput($sformatf("%s m16 ovf", tag), 32'(ovf1), 32'(movf[1]));
    checkOutput($sformatf("%s m16 unf", tag), 32'(unf1), 32'(munf[1]));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b1; sat = 1'b0; load = 1'b0; loadVal = '0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      mq[k] = 0; mpre[k] = 0; movf[k] = 0; munf[k] = 0;
    end
    applyStimulus(1, 0, 1, 0, 0, 0, "reset");

    // Count to 7, then reset mid-count and hold reset for a second cycle.
    for (int i = 0; i < 7 * TB_PRESCALE; i++) applyStimulus(0, 1, 1, 0, 0, 0, "upTo7");
    applyStimulus(1, 1, 1, 0, 0, 0, "rstMid");
    applyStimulus(1, 1, 1, 0, 0, 0, "rstHeld");

    for (int i = 0; i < 11 * TB_PRESCALE; i++) applyStimulus(0, 1, 1, 0, 0, 0, "upWrap");

    applyStimulus(0, 1, 0, 1, 1, 1, "load1");
    for (int i = 0; i < 3 * TB_PRESCALE; i++) applyStimulus(0, 1, 0, 1, 0, 0, "downSat");

    applyStimulus(0, 1, 1, 0, 1, 12, "loadClip");
    applyStimulus(1, 1, 1, 0, 1, 12, "loadRst");
    for (int i = 0; i < 2 * TB_PRESCALE; i++) applyStimulus(0, 1, 0, 0, 0, 0, "downWrap");

    applyStimulus(0, 1, 1, 0, 1, 15, "load15");
    for (int i = 0; i < 2 * TB_PRESCALE; i++) applyStimulus(0, 1, 1, 0, 0, 0, "binWrap");
    for (int i = 0; i < 8; i++) applyStimulus(0, i % 2 == 0, 1, 0, 0, 0, "enToggle");

    applyStimulus(0, 1, 1, 1, 1, 15, "loadMax");
    for (int i = 0; i < 2 * TB_PRESCALE; i++) applyStimulus(0, 1, 1, 1, 0, 0, "upSat");

    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 9) == 0, $urandom_range(0, 15), "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
